// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ write-back requesters.
// Optional define REGFILE_WB_ARB_FWD_EN adds rs1/rs2 bypass outputs from the registered write stage.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
`ifdef REGFILE_WB_ARB_FWD_EN
  input  logic [ADDR_W-1:0]           rs1_addr_i,
  input  logic [ADDR_W-1:0]           rs2_addr_i,
  output logic                        rs1_fwd_hit_o,
  output logic                        rs2_fwd_hit_o,
  output logic [DATA_W-1:0]           rs1_fwd_data_o,
  output logic [DATA_W-1:0]           rs2_fwd_data_o,
`endif
  output logic                        wr_enable_o,
  output logic [ADDR_W-1:0]           wr_addr_o,
  output logic [DATA_W-1:0]           wr_data_o,
  output logic [NUM_REQ-1:0]          grant_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = (32'(base) + off) % NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Search starts at rr_ptr and wraps; the first valid index found wins.
  always_comb begin
    xfer        = 1'b0;
    gnt_idx     = '0;
    req_ready_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!xfer && req_valid_i[rr_index(rr_ptr, i)]) begin
        xfer    = 1'b1;
        gnt_idx = rr_index(rr_ptr, i);
      end
    end
    if (xfer) req_ready_o[gnt_idx] = 1'b1;
  end

  assign sel_addr = req_addr_i[32'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data_i[32'(gnt_idx)*DATA_W +: DATA_W];

  // Writes to x0 are still accepted and granted, only the enable is suppressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      wr_enable_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      grant_o     <= '0;
    end else if (xfer) begin
      rr_ptr      <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      wr_enable_o <= |sel_addr;
      wr_addr_o   <= sel_addr;
      wr_data_o   <= sel_data;
      grant_o     <= NUM_REQ'(1) << gnt_idx;
    end else begin
      wr_enable_o <= 1'b0;
      grant_o     <= '0;
    end
  end

`ifdef REGFILE_WB_ARB_FWD_EN
  // wr_enable_o is never set for x0, so a hit on address 0 cannot occur.
  assign rs1_fwd_hit_o  = wr_enable_o && (wr_addr_o == rs1_addr_i);
  assign rs2_fwd_hit_o  = wr_enable_o && (wr_addr_o == rs2_addr_i);
  assign rs1_fwd_data_o = wr_data_o;
  assign rs2_fwd_data_o = wr_data_o;
`endif

endmodule
